// File: rtl/apb_pkg.sv
// Shared types and widths for the APB memory responder.
// Word-aligned byte addressing; one strobe bit per data byte.
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_SIZE  = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    MEMRD,
    MERGE,
    WAIT,
    RESP
  } resp_state_t;

  typedef enum logic [2:0] {
    FULLWR,
    PARTWR,
    NOPWR,
    RD,
    ERR
  } xfer_kind_t;

  // An illegal address wins over everything; a write with no strobes touches nothing.
  function automatic xfer_kind_t classify(logic bad_addr, logic write,
                                          logic [STRB_SIZE-1:0] strobe);
    if (bad_addr)       return ERR;
    else if (!write)    return RD;
    else if (&strobe)   return FULLWR;
    else if (strobe == '0) return NOPWR;
    else                return PARTWR;
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: strobed lanes take write data, the rest keep memory contents.
module apb_strb_merge
  import apb_pkg::*;
(
  input  logic [STRB_SIZE-1:0]  strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] old_data,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < STRB_SIZE; i++) begin : g_lane
    assign merged[8*i +: 8] = strobe[i] ? wdata[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/apb_mem_responder.sv
// APB responder onto a single-port synchronous memory, with read-modify-write
// for partial strobes, programmable wait states and error responses.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [STRB_SIZE-1:0]  strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int              LSB        = $clog2(STRB_SIZE);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_SIZE);
  localparam bit              NO_WAIT    = (WAIT_STATES == 0);
  localparam logic [3:0]      WAIT_INIT  = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t           state, state_d;
  xfer_kind_t            kind, kind_d;
  logic [3:0]            cnt, cnt_d;
  logic                  rd_2nd, rd_2nd_d;
  logic                  cap_write, cap_write_d;
  logic [STRB_SIZE-1:0]  cap_strobe, cap_strobe_d;
  logic [DATA_WIDTH-1:0] cap_wdata, cap_wdata_d;
  logic [DATA_WIDTH-1:0] rd_buf, rd_buf_d;
  logic                  ready_d, slverr_d, mem_wr_d;
  logic [DATA_WIDTH-1:0] rdata_d, mem_data_in_d, merged;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic                  bad_addr, go_done;

  assign bad_addr = (addr[LSB-1:0] != '0) || ({1'b0, addr} >= ADDR_LIMIT);

  apb_strb_merge u_merge (
    .strobe   (cap_strobe),
    .wdata    (cap_wdata),
    .old_data (mem_data_out),
    .merged   (merged)
  );

  always_comb begin
    state_d       = state;
    kind_d        = kind;
    cnt_d         = cnt;
    rd_2nd_d      = 1'b0;
    cap_write_d   = cap_write;
    cap_strobe_d  = cap_strobe;
    cap_wdata_d   = cap_wdata;
    rd_buf_d      = rd_buf;
    mem_wr_d      = 1'b0;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
    rdata_d       = rdata;
    go_done       = 1'b0;

    case (state)
      IDLE: begin
        if (sel && !enable) begin
          kind_d       = classify(bad_addr, write, strobe);
          cap_write_d  = write;
          cap_strobe_d = strobe;
          cap_wdata_d  = wdata;
          case (kind_d)
            FULLWR: begin
              mem_wr_d      = 1'b1;
              mem_address_d = addr;
              mem_data_in_d = wdata;
              go_done       = 1'b1;
            end
            RD, PARTWR: begin
              mem_address_d = addr;
              state_d       = MEMRD;
            end
            default: go_done = 1'b1;
          endcase
        end
      end
      // Memory data arrives the cycle after the address: a read spends two cycles
      // here, a partial write moves on to merge while that data is on the bus.
      MEMRD: begin
        if (!sel)                 state_d = IDLE;
        else if (kind == PARTWR)  state_d = MERGE;
        else if (!rd_2nd)         rd_2nd_d = 1'b1;
        else begin
          rd_buf_d = mem_data_out;
          go_done  = 1'b1;
        end
      end
      MERGE: begin
        if (!sel) state_d = IDLE;
        else begin
          mem_wr_d      = 1'b1;
          mem_data_in_d = merged;
          go_done       = 1'b1;
        end
      end
      WAIT: begin
        if (!sel)            state_d = IDLE;
        else if (cnt == '0)  state_d = RESP;
        else                 cnt_d   = cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (go_done) begin
      state_d = NO_WAIT ? RESP : WAIT;
      cnt_d   = WAIT_INIT;
    end

    ready_d  = (state_d == RESP);
    slverr_d = ready_d && (kind_d == ERR);
    if (ready_d) begin
      if (kind_d == ERR && !cap_write_d) rdata_d = '0;
      else if (kind_d == RD)             rdata_d = rd_buf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= FULLWR;
      cnt         <= '0;
      rd_2nd      <= 1'b0;
      cap_write   <= 1'b0;
      cap_strobe  <= '0;
      cap_wdata   <= '0;
      rd_buf      <= '0;
      ready       <= 1'b0;
      slverr      <= 1'b0;
      rdata       <= '0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state       <= state_d;
      kind        <= kind_d;
      cnt         <= cnt_d;
      rd_2nd      <= rd_2nd_d;
      cap_write   <= cap_write_d;
      cap_strobe  <= cap_strobe_d;
      cap_wdata   <= cap_wdata_d;
      rd_buf      <= rd_buf_d;
      ready       <= ready_d;
      slverr      <= slverr_d;
      rdata       <= rdata_d;
      mem_wr      <= mem_wr_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Bench for apb_mem_responder: unit 0 has no wait states, unit 1 has two.
// Each unit drives its own memory model; a scoreboard checks ready and mem_wr.
module tb_apb_mem_responder;
  import apb_pkg::*;

  localparam int MEM_DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       sel = '0, enable = '0, write = '0;
  logic [1:0][3:0]  strobe = '0;
  logic [1:0][31:0] addr = '0, wdata = '0;
  logic [1:0]       ready, slverr, mem_wr;
  logic [1:0][31:0] rdata, mem_address, mem_data_in;

  for (genvar g = 0; g < 2; g++) begin : g_u
    logic [31:0] mdo;
    logic [31:0] mem [MEM_DEPTH];

    apb_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(g == 0 ? 0 : 2)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel[g]), .enable(enable[g]), .write(write[g]),
      .strobe(strobe[g]), .addr(addr[g]), .wdata(wdata[g]), .ready(ready[g]),
      .slverr(slverr[g]), .rdata(rdata[g]), .mem_wr(mem_wr[g]),
      .mem_address(mem_address[g]), .mem_data_in(mem_data_in[g]), .mem_data_out(mdo)
    );

    always @(posedge clk) begin
      if (mem_wr[g]) mem[mem_address[g][9:2]] <= mem_data_in[g];
      mdo <= mem[mem_address[g][9:2]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int u; int cyc; logic err; logic chk_rd; logic [31:0] rd; } rsp_t;
  typedef struct { int u; int cyc; logic [31:0] a; logic [31:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int   n_cmp = 0, n_bad = 0;
  logic chk_rst = 1'b0, end_req = 1'b0, end_done = 1'b0;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: pops expectations when the DUT presents ready or mem_wr.
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (chk_rst) begin
      for (int u = 0; u < 2; u++) begin
        cmp("rst_ctl", {29'b0, ready[u], slverr[u], mem_wr[u]}, 32'd0);
        cmp("rst_rdata", rdata[u], 32'd0);
        cmp("rst_maddr", mem_address[u], 32'd0);
        cmp("rst_mdin", mem_data_in[u], 32'd0);
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (slverr[u] && !ready[u]) cmp("slverr_without_ready", 32'd1, 32'd0);
        if (ready[u]) begin
          if (rsp_q.size() != 0 && rsp_q[0].u == u) begin
            r = rsp_q.pop_front();
            cmp("ready_cycle", 32'(cyc), 32'(r.cyc));
            cmp("slverr", {31'b0, slverr[u]}, {31'b0, r.err});
            if (r.chk_rd) cmp("rdata", rdata[u], r.rd);
          end else cmp("unexpected_ready", 32'(u + 1), 32'd0);
        end
        if (mem_wr[u]) begin
          if (wr_q.size() != 0 && wr_q[0].u == u) begin
            w = wr_q.pop_front();
            cmp("mem_wr_cycle", 32'(cyc), 32'(w.cyc));
            cmp("mem_address", mem_address[u], w.a);
            cmp("mem_data_in", mem_data_in[u], w.d);
          end else cmp("unexpected_mem_wr", 32'(u + 1), 32'd0);
        end
      end
      if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc) begin
        cmp("ready_missing_cycle", 32'(cyc), 32'(rsp_q[0].cyc));
        void'(rsp_q.pop_front());
      end
      if (wr_q.size() != 0 && cyc > wr_q[0].cyc) begin
        cmp("mem_wr_missing_cycle", 32'(cyc), 32'(wr_q[0].cyc));
        void'(wr_q.pop_front());
      end
    end
    if (end_req && !end_done) begin
      cmp("rsp_leftover", 32'(rsp_q.size()), 32'd0);
      cmp("wr_leftover", 32'(wr_q.size()), 32'd0);
      end_done <= 1'b1;
    end
  end

  task automatic setup(input int u, input logic wr, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] wd, output int t0);
    @(posedge clk); #1;
    sel[u] = 1'b1; enable[u] = 1'b0; write[u] = wr;
    strobe[u] = st; addr[u] = a; wdata[u] = wd;
    t0 = cyc;
  endtask

  task automatic access(input int u);
    @(posedge clk); #1;
    enable[u] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready[u]) break;
    end
  endtask

  task automatic idle(input int u);
    @(posedge clk); #1;
    sel[u] = 1'b0; enable[u] = 1'b0;
  endtask

  task automatic exp_rsp(input int u, input int c, input logic err,
                         input logic chk, input logic [31:0] rd);
    rsp_t r;
    r.u = u; r.cyc = c; r.err = err; r.chk_rd = chk; r.rd = rd;
    rsp_q.push_back(r);
  endtask

  task automatic exp_wr(input int u, input int c, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.u = u; w.cyc = c; w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  initial begin
    int t0;
    // Reset with random inputs: all outputs must stay at zero.
    chk_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sel = 2'($urandom); enable = 2'($urandom); write = 2'($urandom);
      strobe = 8'($urandom); addr = 64'({$urandom, $urandom}); wdata = 64'({$urandom, $urandom});
    end
    @(posedge clk); #1;
    sel = '0; enable = '0;
    chk_rst = 1'b0; rst_n = 1'b1;
    // Access phase without setup is ignored.
    @(posedge clk); #1;
    sel = '1; enable = '1;
    repeat (3) @(posedge clk);
    #1 sel = '0; enable = '0;
    repeat (2) @(posedge clk);

    // Unit 0, no wait states.
    setup(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, t0);
    exp_wr(0, t0 + 1, 32'h10, 32'hDEADBEEF); exp_rsp(0, t0 + 1, 1'b0, 1'b0, 32'h0);
    access(0);
    setup(0, 1'b0, 4'h0, 32'h10, 32'h0, t0);
    exp_rsp(0, t0 + 3, 1'b0, 1'b1, 32'hDEADBEEF);
    access(0);
    setup(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, t0);
    exp_wr(0, t0 + 3, 32'h10, 32'hDE22BE44); exp_rsp(0, t0 + 3, 1'b0, 1'b0, 32'h0);
    access(0);
    setup(0, 1'b0, 4'h0, 32'h10, 32'h0, t0);
    exp_rsp(0, t0 + 3, 1'b0, 1'b1, 32'hDE22BE44);
    access(0);
    setup(0, 1'b0, 4'h0, 32'h402, 32'h0, t0);
    exp_rsp(0, t0 + 1, 1'b1, 1'b1, 32'h0);
    access(0);
    setup(0, 1'b1, 4'hF, 32'h400, 32'h55AA55AA, t0);
    exp_rsp(0, t0 + 1, 1'b1, 1'b0, 32'h0);
    access(0);
    setup(0, 1'b1, 4'hF, 32'h3FC, 32'hA5A50001, t0);
    exp_wr(0, t0 + 1, 32'h3FC, 32'hA5A50001); exp_rsp(0, t0 + 1, 1'b0, 1'b0, 32'h0);
    access(0);
    setup(0, 1'b0, 4'h0, 32'h3FC, 32'h0, t0);
    exp_rsp(0, t0 + 3, 1'b0, 1'b1, 32'hA5A50001);
    access(0);
    setup(0, 1'b1, 4'h0, 32'h20, 32'h77777777, t0);
    exp_rsp(0, t0 + 1, 1'b0, 1'b0, 32'h0);
    access(0);
    setup(0, 1'b1, 4'hF, 32'h11, 32'h12121212, t0);
    exp_rsp(0, t0 + 1, 1'b1, 1'b0, 32'h0);
    access(0);
    idle(0);

    // Unit 1, two wait states, back-to-back write then read.
    setup(1, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D, t0);
    exp_wr(1, t0 + 1, 32'h10, 32'hCAFEF00D); exp_rsp(1, t0 + 3, 1'b0, 1'b0, 32'h0);
    access(1);
    setup(1, 1'b0, 4'h0, 32'h10, 32'h0, t0);
    exp_rsp(1, t0 + 5, 1'b0, 1'b1, 32'hCAFEF00D);
    access(1);
    setup(1, 1'b1, 4'hF, 32'h20, 32'h12345678, t0);
    exp_wr(1, t0 + 1, 32'h20, 32'h12345678); exp_rsp(1, t0 + 3, 1'b0, 1'b0, 32'h0);
    access(1);
    // Read aborted in T2; a setup in the very next cycle must be accepted.
    setup(1, 1'b0, 4'h0, 32'h20, 32'h0, t0);
    @(posedge clk); #1 enable[1] = 1'b1;
    @(posedge clk); #1 sel[1] = 1'b0; enable[1] = 1'b0;
    setup(1, 1'b0, 4'h0, 32'h20, 32'h0, t0);
    exp_rsp(1, t0 + 5, 1'b0, 1'b1, 32'h12345678);
    access(1);
    // Partial write with reset pulsed in T2: memory must not be written.
    setup(1, 1'b1, 4'b0011, 32'h10, 32'h0, t0);
    @(posedge clk); #1 enable[1] = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; sel[1] = 1'b0; enable[1] = 1'b0;
    setup(1, 1'b0, 4'h0, 32'h10, 32'h0, t0);
    exp_rsp(1, t0 + 5, 1'b0, 1'b1, 32'hCAFEF00D);
    access(1);
    setup(1, 1'b1, 4'b1000, 32'h10, 32'hAB000000, t0);
    exp_wr(1, t0 + 3, 32'h10, 32'hABFEF00D); exp_rsp(1, t0 + 5, 1'b0, 1'b0, 32'h0);
    access(1);
    setup(1, 1'b0, 4'h0, 32'h10, 32'h0, t0);
    exp_rsp(1, t0 + 5, 1'b0, 1'b1, 32'hABFEF00D);
    access(1);
    idle(1);

    repeat (4) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_done; i++) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
